// File: rtl/pending_encoder_32to5.sv
// rtl/pending_encoder_32to5.sv - sticky pending register serialised into binary indices over valid/ready
// Optional macro PENDING_ENCODER_ROUND_ROBIN_EN selects rotating priority; the default is lowest-index-first.
module pending_encoder_32to5 #(
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] req_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             none_o
);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] grant_mask;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             load;
  logic             grant;
  logic             valid;
  logic [IDX_W-1:0] idx;

  assign any   = |pending;
  assign load  = !valid || ready_i;
  assign grant = load && any;

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  // Search begins one past the last grant; index arithmetic wraps since WIDTH is a power of two.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    sel   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      j = ptr + IDX_W'(k + 1);
      if (!found && pending[j]) begin
        sel   = j;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      ptr <= IDX_W'(WIDTH - 1);
    end else if (grant) begin
      ptr <= sel;
    end
  end
`else
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && pending[k]) begin
        sel   = IDX_W'(k);
        found = 1'b1;
      end
    end
  end
`endif

  // A new request for the bit being granted re-sets it, so it counts as a fresh event.
  always_comb begin
    grant_mask   = grant ? (WIDTH'(1) << sel) : '0;
    pending_next = (pending & ~grant_mask) | (en_i ? req_i : '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending <= '0;
      valid   <= 1'b0;
      idx     <= '0;
    end else if (clr_i) begin
      pending <= '0;
      valid   <= 1'b0;
    end else begin
      pending <= pending_next;
      if (load) begin
        valid <= any;
      end
      if (grant) begin
        idx <= sel;
      end
    end
  end

  assign idx_o     = idx;
  assign valid_o   = valid;
  assign pending_o = pending;
  assign none_o    = !any && !valid;

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// tb/tb_pending_encoder_32to5.sv - directed bench for pending_encoder_32to5
module tb_pending_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [31:0] req_i;
  logic        clr_i;
  logic [4:0]  idx_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pending_o;
  logic        none_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pending_encoder_32to5 dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .req_i    (req_i),
    .clr_i    (clr_i),
    .idx_o    (idx_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .pending_o(pending_o),
    .none_o   (none_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [4:0] i,
                           input logic [31:0] p, input logic n);
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    if (v) check({tag, ".idx"}, 32'(idx_o), 32'(i));
    check({tag, ".pending"}, pending_o, p);
    check({tag, ".none"}, 32'(none_o), 32'(n));
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; req_i = 32'hFFFF_FFFF; clr_i = 1'b0; ready_i = 1'b0;
    step(); step();
    check("reset.idx", 32'(idx_o), 32'd0);
    check_out("reset", 1'b0, 5'd0, 32'h0, 1'b1);

    // single event: visible exactly two edges after the request edge
    rst_ni = 1'b1; req_i = 32'h0000_0100; ready_i = 1'b1;
    step(); req_i = 32'h0;
    check_out("single.e0", 1'b0, 5'd0, 32'h100, 1'b0);
    step();
    check_out("single.e1", 1'b1, 5'd8, 32'h0, 1'b0);
    step();
    check_out("single.e2", 1'b0, 5'd0, 32'h0, 1'b1);
    check("single.idx_hold", 32'(idx_o), 32'd8);

    // clear pulse returns any rotation pointer to its reset position
    clr_i = 1'b1; step(); clr_i = 1'b0;

    // multi-hot drain
    req_i = 32'h8000_0005; step(); req_i = 32'h0;
    check_out("multi.load", 1'b0, 5'd0, 32'h8000_0005, 1'b0);
    step(); check_out("multi.0", 1'b1, 5'd0, 32'h8000_0004, 1'b0);
    step(); check_out("multi.2", 1'b1, 5'd2, 32'h8000_0000, 1'b0);
    step(); check_out("multi.31", 1'b1, 5'd31, 32'h0, 1'b0);
    step(); check_out("multi.done", 1'b0, 5'd0, 32'h0, 1'b1);

    // backpressure
    ready_i = 1'b0; req_i = 32'h0000_0030; step(); req_i = 32'h0;
    check_out("bp.load", 1'b0, 5'd0, 32'h30, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(); check_out("bp.stall", 1'b1, 5'd4, 32'h20, 1'b0);
    end
    ready_i = 1'b1;
    step(); check_out("bp.next", 1'b1, 5'd5, 32'h0, 1'b0);
    step(); check_out("bp.done", 1'b0, 5'd0, 32'h0, 1'b1);

    // collision: request for bit 3 on the edge that grants it
    req_i = 32'h0000_0008; step();
    check_out("coll.load", 1'b0, 5'd0, 32'h8, 1'b0);
    step(); req_i = 32'h0;
    check_out("coll.first", 1'b1, 5'd3, 32'h8, 1'b0);
    step(); check_out("coll.second", 1'b1, 5'd3, 32'h0, 1'b0);
    step(); check_out("coll.done", 1'b0, 5'd0, 32'h0, 1'b1);

    // clear outranks a request and a held output
    ready_i = 1'b0; req_i = 32'h0000_0004; step(); req_i = 32'h0;
    step(); check_out("clr.held", 1'b1, 5'd2, 32'h0, 1'b0);
    clr_i = 1'b1; req_i = 32'h0000_0001; step(); clr_i = 1'b0; req_i = 32'h0;
    check_out("clr.flush", 1'b0, 5'd0, 32'h0, 1'b1);
    check("clr.idx_hold", 32'(idx_o), 32'd2);
    step(); check_out("clr.after", 1'b0, 5'd0, 32'h0, 1'b1);

    // en_i low ignores requests
    ready_i = 1'b1; en_i = 1'b0; req_i = 32'h0000_0010; step(); step();
    en_i = 1'b1; req_i = 32'h0;
    check_out("en_off", 1'b0, 5'd0, 32'h0, 1'b1);

    // held two-bit request: priority behaviour
    req_i = 32'h0000_0003; step();
    check_out("prio.load", 1'b0, 5'd0, 32'h3, 1'b0);
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    step(); check_out("rr.0a", 1'b1, 5'd0, 32'h3, 1'b0);
    step(); check_out("rr.1a", 1'b1, 5'd1, 32'h3, 1'b0);
    step(); check_out("rr.0b", 1'b1, 5'd0, 32'h3, 1'b0);
    step(); check_out("rr.1b", 1'b1, 5'd1, 32'h3, 1'b0);
`else
    for (int c = 0; c < 4; c++) begin
      step(); check_out("fixed.0", 1'b1, 5'd0, 32'h3, 1'b0);
    end
`endif
    req_i = 32'h0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
